griffin_nl_eval: RTL and testbench

Sequential evaluator for the per-lane Griffin nonlinear term. For each element it computes y_i = x_i · (L_i² + α_i·L_i + β_i) mod P from one L_i value produced by the linear-combination stage. It sits directly downstream of that stage in the pipelined Griffin permutation. It evaluates Horner-style as y = x·(L·(L+α) + β), using one shared galois_mult_254 instance twice per element, with valid/ready handshakes on both sides.

---
 rtl/griffin_nl_eval.sv | 176 +++++++++++++++++
 tb/tb_griffin_nl_eval.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/griffin_nl_eval.sv
// Griffin nonlinear lane evaluator: y = x * (L*(L+alpha) + beta) mod P,
// evaluated with one shared modular multiplier used twice per element.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new element (in_ready=1)
// MUL1  | multiplier works on (L+alpha, L); t3 captured on expiry
// MUL2  | multiplier works on (t3, x); y captured on expiry
// DONE  | y valid, held until the consumer takes it

// Modular multiplier. The consumer registers the product at the MULT_LAT-th
// edge after the operands are applied, so this block holds MULT_LAT-1 stages
// and presents a combinational result when MULT_LAT is 1.
module galois_mult_254 #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                MULT_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] p
);
  localparam int W2 = 2 * N_BITS;

  logic [W2-1:0]     full;
  logic [N_BITS-1:0] p_c;

  assign full = W2'(a) * W2'(b);
  assign p_c  = N_BITS'(full % W2'(PRIME_MODULUS));

  if (MULT_LAT == 1) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign p = p_c;
  end else begin : g_pipe
    logic [N_BITS-1:0] stage [MULT_LAT-1];

    // Delay line so the result arrives exactly at the consumer's capture edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MULT_LAT - 1; i++) stage[i] <= '0;
      end else begin
        stage[0] <= p_c;
        for (int i = 1; i < MULT_LAT - 1; i++) stage[i] <= stage[i-1];
      end
    end

    assign p = stage[MULT_LAT-2];
  end
endmodule

module griffin_nl_eval #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                MULT_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] l_i,
  input  logic [N_BITS-1:0] x_i,
  input  logic [N_BITS-1:0] alpha,
  input  logic [N_BITS-1:0] beta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] y_i
);
  localparam int            CW     = $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] LAT_LD = CW'(MULT_LAT);
  localparam logic [CW-1:0] CNT_TC = CW'(1);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ld_in, ld_t3, ld_y;
  logic [N_BITS-1:0] l_q, x_q, alpha_q, beta_q, t3_q, y_q;
  logic [N_BITS-1:0] l_plus_a, mul_a, mul_b, prod;

  // Both operands are already canonical, so a single conditional subtract suffices
  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME_MODULUS}) s = s - {1'b0, PRIME_MODULUS};
    return N_BITS'(s);
  endfunction

  assign l_plus_a = add_mod(l_q, alpha_q);
  assign mul_a    = (state == MUL2) ? t3_q : l_plus_a;
  assign mul_b    = (state == MUL2) ? x_q  : l_q;

  galois_mult_254 #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .MULT_LAT      (MULT_LAT)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  // Next-state, latency down-counter and register load enables
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_in     = 1'b0;
    ld_t3     = 1'b0;
    ld_y      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ld_in     = 1'b1;
          cnt_nxt   = LAT_LD;
          state_nxt = MUL1;
        end
      end
      MUL1: begin
        if (cnt == CNT_TC) begin
          ld_t3     = 1'b1;
          cnt_nxt   = LAT_LD;
          state_nxt = MUL2;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      MUL2: begin
        if (cnt == CNT_TC) begin
          ld_y      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and datapath registers; reset drops any in-flight element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      l_q     <= '0;
      x_q     <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
      t3_q    <= '0;
      y_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ld_in) begin
        l_q     <= l_i;
        x_q     <= x_i;
        alpha_q <= alpha;
        beta_q  <= beta;
      end
      if (ld_t3) t3_q <= add_mod(prod, beta_q);
      if (ld_y)  y_q  <= prod;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y_i       = y_q;
endmodule

// File: tb/tb_griffin_nl_eval.sv
// Directed and streaming bench for griffin_nl_eval. Two instances (MULT_LAT 1
// and 3) share the same input stimulus and are checked independently.
module tb_griffin_nl_eval;
  localparam logic [253:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef struct {
    logic [253:0] l;
    logic [253:0] x;
    logic [253:0] a;
    logic [253:0] b;
    logic [253:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [253:0] l_i, x_i, alpha, beta;
  logic         ir1, ov1, ir3, ov3;
  logic [253:0] y1, y3;

  int n_checks = 0;
  int n_pass   = 0;

  bit           stream_on = 1'b0;
  int           cyc = 0;
  logic [253:0] q1[$];
  logic [253:0] q3[$];
  int           last_acc[2];
  bit           have_acc[2];
  bit           stalled[2];
  int           n_out[2];

  always #5 clk = ~clk;

  griffin_nl_eval #(.MULT_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .l_i(l_i), .x_i(x_i), .alpha(alpha), .beta(beta),
    .out_valid(ov1), .out_ready(out_ready), .y_i(y1)
  );

  griffin_nl_eval #(.MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .l_i(l_i), .x_i(x_i), .alpha(alpha), .beta(beta),
    .out_valid(ov3), .out_ready(out_ready), .y_i(y3)
  );

  task automatic check(input string name, input logic [253:0] act, input logic [253:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [253:0] addm(input logic [253:0] a, input logic [253:0] b);
    logic [254:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[253:0];
  endfunction

  // Double-and-add reference multiplier
  function automatic logic [253:0] mulm(input logic [253:0] a, input logic [253:0] b);
    logic [253:0] r;
    r = '0;
    for (int i = 253; i >= 0; i--) begin
      r = addm(r, r);
      if (b[i]) r = addm(r, a);
    end
    return r;
  endfunction

  function automatic logic [253:0] model(input logic [253:0] l, input logic [253:0] x,
                                         input logic [253:0] a, input logic [253:0] b);
    return mulm(addm(mulm(addm(l, a), l), b), x);
  endfunction

  function automatic logic [253:0] rnd_fe();
    logic [255:0] w;
    logic [253:0] r;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    r = w[253:0];
    while (r >= P) r = r - P;
    return r;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 20 && !(ir1 && ir3); i++) @(negedge clk);
    check("idle", {252'd0, ir1, ir3}, 254'd3);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat1, lat3;
    logic [253:0] c1, c3;
    @(negedge clk);
    l_i = v.l; x_i = v.x; alpha = v.a; beta = v.b;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat1 = -1; lat3 = -1; c1 = '0; c3 = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ov1 && lat1 < 0) begin lat1 = c; c1 = y1; end
      if (ov3 && lat3 < 0) begin lat3 = c; c3 = y3; end
      if (lat1 >= 0 && lat3 >= 0) break;
    end
    check({tag, "_lat1"}, 254'(lat1), 254'd2);
    check({tag, "_lat3"}, 254'(lat3), 254'd6);
    check({tag, "_y1"}, c1, v.y);
    check({tag, "_y3"}, c3, v.y);
    wait_idle();
  endtask

  task automatic mon(input int idx, input logic ir, input logic ov, input logic [253:0] y);
    logic [253:0] e;
    int ii;
    ii = (idx == 0) ? 4 : 8;
    if (ov && out_ready) begin
      n_out[idx]++;
      if ((idx == 0 && q1.size() == 0) || (idx == 1 && q3.size() == 0)) begin
        n_checks++;
        $display("FAIL stream_extra%0d: output %0h with no pending element", idx, y);
      end else begin
        e = (idx == 0) ? q1.pop_front() : q3.pop_front();
        check($sformatf("stream_y%0d", idx), y, e);
      end
    end
    if (ov && !out_ready) stalled[idx] = 1'b1;
    if (in_valid && ir) begin
      if (have_acc[idx] && !stalled[idx])
        check($sformatf("stream_ii%0d", idx), 254'(cyc - last_acc[idx]), 254'(ii));
      e = model(l_i, x_i, alpha, beta);
      if (idx == 0) q1.push_back(e); else q3.push_back(e);
      last_acc[idx] = cyc;
      have_acc[idx] = 1'b1;
      stalled[idx]  = 1'b0;
    end
  endtask

  // Streaming scoreboard; sampled mid-cycle where inputs and outputs are settled
  always @(negedge clk) begin
    cyc++;
    if (stream_on) begin
      mon(0, ir1, ov1, y1);
      mon(1, ir3, ov3, y3);
    end
  end

  initial begin
    vec_t vt[8];
    vec_t rv;
    vt[0] = '{l: 254'd3,    x: 254'd5,    a: 254'd2,    b: 254'd7,    y: 254'd110};
    vt[1] = '{l: P - 254'd1, x: 254'd6,   a: 254'd1,    b: 254'd4,    y: 254'd24};
    vt[2] = '{l: P - 254'd1, x: 254'd1,   a: 254'd0,    b: 254'd0,    y: 254'd1};
    vt[3] = '{l: 254'd0,    x: 254'd2,    a: 254'd0,    b: P - 254'd1, y: P - 254'd2};
    vt[4] = '{l: 254'd0,    x: 254'd9,    a: 254'd0,    b: 254'd0,    y: 254'd0};
    vt[5] = '{l: 254'd1,    x: 254'd7,    a: P - 254'd1, b: 254'd5,   y: 254'd35};
    vt[6] = '{l: 254'd2,    x: P - 254'd1, a: 254'd3,   b: 254'd1,    y: P - 254'd11};
    vt[7] = '{l: 254'd10,   x: 254'd3,    a: 254'd20,   b: 254'd5,    y: 254'd915};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    l_i = '0; x_i = '0; alpha = '0; beta = '0;
    #3;
    check("rst_ov1", {253'd0, ov1}, 254'd0);
    check("rst_ir1", {253'd0, ir1}, 254'd1);
    check("rst_y1", y1, 254'd0);
    check("rst_ov3", {253'd0, ov3}, 254'd0);
    check("rst_ir3", {253'd0, ir3}, 254'd1);
    check("rst_y3", y3, 254'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Backpressure: hold the result, ignore new inputs, then release
    @(negedge clk);
    l_i = 254'd3; x_i = 254'd5; alpha = 254'd2; beta = 254'd7;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 20 && !ov3; i++) @(negedge clk);
    check("bp_ov3", {253'd0, ov3}, 254'd1);
    for (int i = 0; i < 10; i++) begin
      l_i = 254'(i + 40); x_i = 254'(i + 1); alpha = 254'd9; beta = 254'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_y1", y1, 254'd110);
      check("bp_y3", y3, 254'd110);
      check("bp_state1", {252'd0, ov1, ir1}, 254'd2);
      check("bp_state3", {252'd0, ov3, ir3}, 254'd2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel1", {252'd0, ov1, ir1}, 254'd1);
    check("bp_rel3", {252'd0, ov3, ir3}, 254'd1);
    repeat (8) @(negedge clk);
    check("bp_quiet", {252'd0, ov1, ov3}, 254'd0);

    // Asynchronous reset between edges while the MULT_LAT=1 instance is in MUL2
    @(negedge clk);
    l_i = 254'd4; x_i = 254'd4; alpha = 254'd4; beta = 254'd4;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ov1", {253'd0, ov1}, 254'd0);
    check("arst_ir1", {253'd0, ir1}, 254'd1);
    check("arst_y1", y1, 254'd0);
    check("arst_ov3", {253'd0, ov3}, 254'd0);
    check("arst_ir3", {253'd0, ir3}, 254'd1);
    check("arst_y3", y3, 254'd0);
    @(negedge clk); rst = 1'b0;
    run_vec("post_rst", vt[0]);

    // Streaming with random backpressure
    for (int k = 0; k < 2; k++) begin
      have_acc[k] = 1'b0; stalled[k] = 1'b0; n_out[k] = 0;
    end
    @(posedge clk); #2;
    stream_on = 1'b1;
    for (int c = 0; c < 4000 && n_out[1] < 50; c++) begin
      l_i = rnd_fe(); x_i = rnd_fe(); alpha = rnd_fe(); beta = rnd_fe();
      in_valid = 1'b1;
      out_ready = (c < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    @(negedge clk);
    stream_on = 1'b0;
    in_valid = 1'b0;
    check("stream_cnt1", 254'(n_out[0] >= 50), 254'd1);
    check("stream_cnt3", 254'(n_out[1] >= 50), 254'd1);
    check("stream_pend1", 254'(q1.size() <= 1), 254'd1);
    check("stream_pend3", 254'(q3.size() <= 1), 254'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
